// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock time-setting sequencer.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    localparam logic [5:0] HR_BLINK  = 6'b110000;
    localparam logic [5:0] MIN_BLINK = 6'b001100;
    localparam logic [5:0] SEC_BLINK = 6'b000011;

    // Bit offsets of each 2-digit BCD field inside the 24-bit time word
    localparam int unsigned HR_LSB  = 16;
    localparam int unsigned MIN_LSB = 8;
    localparam int unsigned SEC_LSB = 0;

endpackage

// File: rtl/bcd_field_inc.sv
// Wrapped increment of one 2-digit BCD field; out-of-range or malformed values restart at 00.
module bcd_field_inc (
    input  logic [7:0] field,
    input  logic [7:0] max_val,
    output logic [7:0] field_nx
);

    logic bad_digit;

    always_comb begin
        bad_digit = (field[3:0] > 4'd9) || (field[7:4] > max_val[7:4]);
        field_nx  = 8'h00;
        // Digits are valid BCD past this point, so a plain compare orders them numerically
        if (bad_digit || (field >= max_val)) begin
            field_nx = 8'h00;
        end else if (field[3:0] == 4'd9) begin
            field_nx = {field[7:4] + 4'd1, 4'd0};
        end else begin
            field_nx = {field[7:4], field[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Time-setting sequencer: pauses the BCD counter, edits a shadow copy field by field,
// then commits it with a one-cycle parallel load.
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DLY  = 25_000_000,
    parameter int unsigned REPEAT_RATE = 5_000_000,
    parameter int unsigned TIMEOUT_S   = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] cur_time,
    output logic        run_en,
    output logic        load,
    output logic [23:0] load_time,
    output logic [5:0]  blink_mask,
    output logic        set_active
);

    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_S + 1);

    state_t             state, state_nx;
    logic               mode_q, inc_q;
    logic [23:0]        shadow, shadow_inc;
    logic [REP_W-1:0]   rep_cnt;
    logic               rep_arm;
    logic [TO_W-1:0]    to_cnt;
    logic               phase;

    logic               mode_edge, inc_edge;
    logic               in_set, in_set_nx;
    logic               rep_fire, abort, inc_evt;
    logic [7:0]         sel_field, sel_max, field_nx;

    always_comb begin
        mode_edge = btn_mode & ~mode_q;
        inc_edge  = btn_inc & ~inc_q;
        in_set    = (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);
        rep_fire  = in_set & rep_arm & btn_inc & (rep_cnt == '0);
        // A button edge restarts the timeout, so it also cancels an abort on the same tick
        abort     = in_set & tick_1hz & (to_cnt == TO_W'(1)) & ~mode_edge & ~inc_edge;
        inc_evt   = in_set & (inc_edge | rep_fire) & ~mode_edge & ~abort;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (mode_edge) state_nx = SET_HR;
            SET_HR:  if (mode_edge) state_nx = SET_MIN; else if (abort) state_nx = RUN;
            SET_MIN: if (mode_edge) state_nx = SET_SEC; else if (abort) state_nx = RUN;
            SET_SEC: if (mode_edge) state_nx = COMMIT;  else if (abort) state_nx = RUN;
            COMMIT:  state_nx = RUN;
            default: state_nx = RUN;
        endcase
        in_set_nx = (state_nx == SET_HR) || (state_nx == SET_MIN) || (state_nx == SET_SEC);
    end

    always_comb begin
        sel_field = shadow[HR_LSB +: 8];
        sel_max   = HR_MAX;
        case (state)
            SET_MIN: begin
                sel_field = shadow[MIN_LSB +: 8];
                sel_max   = MS_MAX;
            end
            SET_SEC: begin
                sel_field = shadow[SEC_LSB +: 8];
                sel_max   = MS_MAX;
            end
            default: begin
                sel_field = shadow[HR_LSB +: 8];
                sel_max   = HR_MAX;
            end
        endcase
    end

    bcd_field_inc u_field_inc (
        .field    (sel_field),
        .max_val  (sel_max),
        .field_nx (field_nx)
    );

    always_comb begin
        shadow_inc = shadow;
        case (state)
            SET_HR:  shadow_inc[HR_LSB +: 8]  = field_nx;
            SET_MIN: shadow_inc[MIN_LSB +: 8] = field_nx;
            SET_SEC: shadow_inc[SEC_LSB +: 8] = field_nx;
            default: shadow_inc = shadow;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RUN;
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
            shadow  <= '0;
            rep_cnt <= '0;
            rep_arm <= 1'b0;
            to_cnt  <= '0;
            phase   <= 1'b0;
        end else begin
            state  <= state_nx;
            mode_q <= btn_mode;
            inc_q  <= btn_inc;

            if ((state == RUN) && mode_edge) begin
                shadow <= cur_time;
            end else if (inc_evt) begin
                shadow <= shadow_inc;
            end

            if (!in_set || !btn_inc || (state_nx != state)) begin
                rep_arm <= 1'b0;
                rep_cnt <= '0;
            end else if (inc_edge) begin
                rep_arm <= 1'b1;
                rep_cnt <= REP_W'(REPEAT_DLY - 1);
            end else if (rep_arm) begin
                rep_cnt <= (rep_cnt == '0) ? REP_W'(REPEAT_RATE - 1) : rep_cnt - 1'b1;
            end

            if (((state == RUN) && mode_edge) || (in_set && (mode_edge || inc_edge))) begin
                to_cnt <= TO_W'(TIMEOUT_S);
            end else if (in_set && tick_1hz) begin
                to_cnt <= to_cnt - 1'b1;
            end

            if (!in_set_nx) begin
                phase <= 1'b0;
            end else if (in_set && tick_1hz) begin
                phase <= ~phase;
            end
        end
    end

    always_comb begin
        run_en     = (state == RUN);
        load       = (state == COMMIT);
        load_time  = shadow;
        set_active = in_set;
        blink_mask = 6'b000000;
        if (phase) begin
            case (state)
                SET_HR:  blink_mask = HR_BLINK;
                SET_MIN: blink_mask = MIN_BLINK;
                SET_SEC: blink_mask = SEC_BLINK;
                default: blink_mask = 6'b000000;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller; load pulses are checked against a queue of expected times.
module tb_clock_set_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_inc;
    logic [23:0] cur_time;
    logic        run_en;
    logic        load;
    logic [23:0] load_time;
    logic [5:0]  blink_mask;
    logic        set_active;

    int tests = 0;
    int fails = 0;
    logic [23:0] exp_q[$];

    clock_set_controller #(
        .REPEAT_DLY  (10),
        .REPEAT_RATE (4),
        .TIMEOUT_S   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_time   (cur_time),
        .run_en     (run_en),
        .load       (load),
        .load_time  (load_time),
        .blink_mask (blink_mask),
        .set_active (set_active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; step();
        btn_mode = 1'b0; step();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; step();
        btn_inc = 1'b0; step();
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1; step();
        tick_1hz = 1'b0; step();
    endtask

    // Monitor: every load pulse must match the oldest expected time and be followed by RUN
    always begin
        @(negedge clk);
        if (load === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_load: got load_time %h expected no load", load_time);
            end else begin
                logic [23:0] exp_t;
                exp_t = exp_q.pop_front();
                if (load_time !== exp_t || run_en !== 1'b0) begin
                    fails++;
                    $display("FAIL load_time: got %h run_en %b expected %h run_en 0",
                             load_time, run_en, exp_t);
                end
            end
            @(negedge clk);
            tests++;
            if (load !== 1'b0 || run_en !== 1'b1) begin
                fails++;
                $display("FAIL after_load: got load %b run_en %b expected load 0 run_en 1",
                         load, run_en);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cur_time = 24'h12_34_56;
        step(); step();
        check("rst_run_en",     24'(run_en),     24'h1);
        check("rst_load",       24'(load),       24'h0);
        check("rst_blink",      24'(blink_mask), 24'h0);
        check("rst_set_active", 24'(set_active), 24'h0);
        check("rst_load_time",  load_time,       24'h0);
        reset = 1'b1;
        step();

        // Main edit: 12:34:56 -> 15:35:57
        press_mode();
        check("set_hr_active", 24'(set_active), 24'h1);
        check("set_hr_run_en", 24'(run_en),     24'h0);
        check("set_hr_blink0", 24'(blink_mask), 24'h0);
        repeat (3) press_inc();
        press_mode();
        pulse_tick();
        check("blink_min", 24'(blink_mask), 24'h0C);
        press_inc();
        press_mode();
        check("blink_sec", 24'(blink_mask), 24'h03);
        press_inc();
        exp_q.push_back(24'h15_35_57);
        press_mode();
        step();

        // Wrap every field from 23:59:59
        cur_time = 24'h23_59_59;
        press_mode(); press_inc();
        press_mode(); press_inc();
        press_mode(); press_inc();
        exp_q.push_back(24'h00_00_00);
        press_mode();
        step();

        // Malformed hours field
        cur_time = 24'h2A_10_05;
        press_mode(); press_inc();
        press_mode(); press_mode();
        exp_q.push_back(24'h00_10_05);
        press_mode();
        step();

        // Auto-repeat in SET_MIN: edge plus two repeats
        cur_time = 24'h08_00_30;
        press_mode(); press_mode();
        btn_inc = 1'b1;
        repeat (18) step();
        btn_inc = 1'b0;
        step();
        press_mode();
        exp_q.push_back(24'h08_03_30);
        press_mode();
        step();

        // Timeout with no buttons
        cur_time = 24'h01_02_03;
        press_mode();
        pulse_tick();
        check("to_blink_on",  24'(blink_mask), 24'h30);
        pulse_tick();
        check("to_still_set", 24'(set_active), 24'h1);
        pulse_tick();
        check("to_abort_set", 24'(set_active), 24'h0);
        check("to_abort_run", 24'(run_en),     24'h1);

        // Timeout restarted by an inc edge
        press_mode();
        pulse_tick(); pulse_tick();
        check("tr_blink_off", 24'(blink_mask), 24'h0);
        press_inc();
        pulse_tick(); pulse_tick();
        check("tr_still_set", 24'(set_active), 24'h1);
        pulse_tick();
        check("tr_abort_set", 24'(set_active), 24'h0);
        check("tr_abort_run", 24'(run_en),     24'h1);

        // Same-cycle mode and inc edges in SET_HR
        cur_time = 24'h12_34_56;
        press_mode();
        btn_mode = 1'b1; btn_inc = 1'b1; step();
        btn_mode = 1'b0; btn_inc = 1'b0; step();
        check("both_blink_min", 24'(set_active), 24'h1);
        press_inc();
        press_mode();
        exp_q.push_back(24'h12_35_56);
        press_mode();
        step();

        // Reset in SET_SEC aborts without loading
        cur_time = 24'h09_09_09;
        press_mode(); press_mode(); press_mode();
        press_inc();
        reset = 1'b0;
        step();
        check("rs_set_active", 24'(set_active), 24'h0);
        check("rs_run_en",     24'(run_en),     24'h1);
        check("rs_load",       24'(load),       24'h0);
        check("rs_load_time",  load_time,       24'h0);
        reset = 1'b1;
        repeat (4) step();

        check("loads_pending", 24'(exp_q.size()), 24'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Time-setting sequencer for the digital clock: a mode/increment FSM in front of the BCD time counter.
- Pauses timekeeping, captures the current time into shadow registers, and lets the user step hours, minutes and seconds with two buttons.
- Commits the edited time to the counter with a one-cycle parallel load.
- Drives per-digit blink enables for the seven-segment decoders.
- Runs on the 50 MHz system clock; the 1 Hz tick arrives as a single-cycle enable.

Parameters:
- REPEAT_DLY, 25_000_000, clk cycles btn_inc must be held before auto-repeat starts (0.5 s).
- REPEAT_RATE, 5_000_000, clk cycles between auto-repeat increments (0.1 s).
- TIMEOUT_S, 30, tick_1hz pulses with no button edge before setting is aborted.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse per second from the clock divider.
- btn_mode  in  1  mode button, already synchronised and debounced, level.
- btn_inc  in  1  increment button, already synchronised and debounced, level.
- cur_time  in  24  current time {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}, 4-bit BCD each.
- run_en  out  1  counter count enable; gates tick_1hz into the counter.
- load  out  1  one-cycle parallel-load strobe to the counter.
- load_time  out  24  time to load, same packing as cur_time.
- blink_mask  out  6  per-digit blank request, bit5 = hr_tens … bit0 = sec_ones.
- set_active  out  1  high in any SET state.

Behaviour:
- Reset (reset==0 at a clk edge) applies these values:
  - state=RUN, run_en=1, load=0, load_time=0, blink_mask=0, set_active=0.
  - Shadow registers, repeat counter, timeout counter and blink phase all 0.
- Reset mid-set aborts with no load.
- Edge detect: registered previous levels; a press is a 0->1 transition. Edges are acted on in the cycle they are detected; shadow and outputs update at the next clk edge.
- States: RUN -> SET_HR -> SET_MIN -> SET_SEC -> COMMIT -> RUN.
  - RUN + mode edge: capture cur_time into shadow, go to SET_HR, run_en=0 from the next cycle.
  - SET_HR + mode edge: go to SET_MIN. SET_MIN + mode edge: go to SET_SEC.
  - SET_SEC + mode edge: go to COMMIT.
  - COMMIT lasts exactly 1 cycle: load=1, load_time=shadow, run_en=0. The next cycle is RUN with run_en=1 and load=0.
  - Any SET state + timeout expiry: go to RUN, run_en=1, no load. The counter keeps its pre-set value.
- Increment, SET states only. An inc edge or auto-repeat event bumps the selected field's 2-digit BCD:
  - ones 9 -> 0 with tens+1.
  - Hours wrap 23 -> 00. Minutes and seconds wrap 59 -> 00.
  - Invalid BCD in the field (ones>9, or tens beyond the field max) -> field becomes 00.
  - Other fields are untouched.
- Auto-repeat while btn_inc stays high in a SET state:
  - Counter starts at the press edge.
  - First repeat fires REPEAT_DLY cycles after the edge, then every REPEAT_RATE cycles.
  - Release or a state change clears the counter.
- Simultaneous events:
  - Mode edge and inc event in the same cycle: mode wins, inc is discarded.
  - A mode edge in COMMIT is ignored.
  - Both buttons' edges restart the timeout counter.
- Timeout:
  - Counts tick_1hz pulses while in a SET state; cleared on entering SET_HR and on any button edge.
  - Abort fires when the count reaches TIMEOUT_S.
- Blink:
  - Phase toggles on each tick_1hz while in a SET state; phase is 0 in RUN.
  - blink_mask = phase ? mask of the selected field's two digits : 0.
  - Field masks: hours 110000, minutes 001100, seconds 000011.
- tick_1hz is ignored for timekeeping here; the counter sees it only through run_en.

Decomposition:
- Package clock_ctrl_pkg holds:
  - the state enum (RUN, SET_HR, SET_MIN, SET_SEC, COMMIT);
  - field max constants HR_MAX=8'h23, MS_MAX=8'h59;
  - field blink-mask constants;
  - the 24-bit time packing offsets.
- Sub-module bcd_field_inc, combinational: in = 8-bit BCD field and 8-bit max, out = wrapped increment including the invalid->00 rule. Instantiated once; the FSM selects which field feeds it.

Test Plan:
- Reset with cur_time=12:34:56 -> run_en=1, load=0, blink_mask=0, state RUN.
- Mode, inc x3, mode, inc x1, mode, inc x1, mode from 12:34:56 -> exactly one load pulse, load_time=15:35:57, run_en=1 on the cycle after load.
- Wrap checks:
  - SET_HR from 23 + inc -> 00.
  - SET_MIN from 59 + inc -> 00.
  - Captured hr field 8'h2A + inc -> 00.
- btn_inc held REPEAT_DLY+2*REPEAT_RATE cycles (sim params 10/4) in SET_MIN from 00 -> minutes 03 (edge + 2 repeats).
- Enter SET_HR, no buttons for TIMEOUT_S (sim 3) ticks -> RUN, run_en=1, no load. Same case with an inc edge before expiry -> timer restarts.
- Edge cases:
  - Same-cycle mode+inc edges in SET_HR -> SET_MIN, hours unchanged.
  - reset asserted in SET_SEC -> RUN next cycle, no load pulse ever issued.
